// File: rtl/usb_tx_sched_pkg.sv
// usb_pkg: shared constants and state encoding for the USB TX scheduler.
package usb_pkg;

    // Byte presented while the serializer hunts for the start of a frame.
    localparam logic [7:0] SYNC_DATA = 8'h01;

    // Every byte occupies this many clock cycles on the serializer.
    localparam int SLOT_LEN = 8;
    localparam logic [2:0] SLOT_LAST = 3'(SLOT_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_SYNC  = 3'd2,
        ST_SEND  = 3'd3,
        ST_GUARD = 3'd4
    } state_t;

    // True on the final cycle of a byte slot.
    function automatic logic slot_end(input logic [2:0] slot);
        return slot == SLOT_LAST;
    endfunction

endpackage

// File: rtl/usb_tx_sched_if.sv
// usb_tx_sched_if: requester-side and serializer-side signals of the scheduler.
interface usb_tx_sched_if #(
    parameter int NREQ  = 2,
    parameter int LEN_W = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] len;
    logic [NREQ*8-1:0]     rdata;
    logic [NREQ-1:0]       pop;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic                  fs;
    logic [7:0]            txd;
    logic                  fire;

    // The scheduler side.
    modport master (
        input  req, len, rdata, fire,
        output pop, gnt, done, err, fs, txd
    );

    // The FIFO / serializer side.
    modport slave (
        output req, len, rdata, fire,
        input  pop, gnt, done, err, fs, txd
    );
endinterface

// File: rtl/usb_tx_sched_rr_arbiter.sv
// rr_arbiter: picks the first pending request at or after the pointer,
// wrapping around; purely combinational.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    localparam logic [IDX_W:0] NREQ_V = (IDX_W + 1)'(NREQ);

    logic [NREQ-1:0]  w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W:0]   w_wrap;

    // Rotate the request vector so bit 0 is the requester at the pointer.
    always_comb begin
        w_rot = NREQ'({i_req, i_req} >> i_ptr);
    end

    // Lowest set bit of the rotated vector is the closest requester.
    always_comb begin
        w_off = '0;
        o_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
                o_any = 1'b1;
            end
        end
    end

    // Map the rotated offset back to an absolute requester index.
    always_comb begin
        w_sum  = {1'b0, i_ptr} + {1'b0, w_off};
        w_wrap = (w_sum >= NREQ_V) ? (w_sum - NREQ_V) : w_sum;
        o_idx  = w_wrap[IDX_W-1:0];
        o_gnt  = o_any ? ({{(NREQ-1){1'b0}}, 1'b1} << o_idx) : '0;
    end

endmodule

// File: rtl/usb_tx_sched.sv
// usb_tx_sched: shares one USB byte serializer between NREQ requesters.
// Each packet is SYNC (0x01) followed by len payload bytes, one byte per
// 8-cycle slot; fs drops with the last byte, and the next grant waits until
// the serializer's guard period (fire low) is over.
module usb_tx_sched
    import usb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int LEN_W  = 8,
    parameter int TO_CYC = 64
) (
    input logic            clk,
    input logic            rst_n,
    usb_tx_sched_if.master bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TO_CYC - 1);
    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

    state_t           r_state, w_state;
    logic [LEN_W-1:0] r_cnt,   w_cnt;
    logic [2:0]       r_slot,  w_slot;
    logic [TMO_W-1:0] r_tmo,   w_tmo;
    logic [IDX_W-1:0] r_ptr,   w_ptr;
    logic [IDX_W-1:0] r_idx,   w_idx;
    logic             r_abort, w_abort;
    logic             r_fs,    w_fs;
    logic [7:0]       r_txd,   w_txd;
    logic [NREQ-1:0]  r_gnt,   w_gnt;
    logic [NREQ-1:0]  r_pop,   w_pop;
    logic [NREQ-1:0]  r_done,  w_done;
    logic             r_err,   w_err;

    logic [NREQ-1:0]  w_arb_gnt;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_any;
    logic [LEN_W-1:0] w_len_sel;
    logic [7:0]       w_rdata_sel;
    logic [IDX_W-1:0] w_ptr_next;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // Length of the requester the arbiter would grant this cycle.
    always_comb begin
        w_len_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_gnt[i]) begin
                w_len_sel = bus.len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Head-of-FIFO byte of the currently granted requester.
    always_comb begin
        w_rdata_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_rdata_sel = bus.rdata[i*8 +: 8];
            end
        end
    end

    // Pointer moves one past the requester that just finished.
    always_comb begin
        w_ptr_next = (r_idx == LAST_IDX) ? '0 : (r_idx + 1'b1);
    end

    // Next-state and next-output logic of the packet FSM.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_slot  = r_slot;
        w_tmo   = r_tmo;
        w_ptr   = r_ptr;
        w_idx   = r_idx;
        w_abort = r_abort;
        w_fs    = r_fs;
        w_txd   = r_txd;
        w_gnt   = r_gnt;
        w_pop   = '0;
        w_done  = '0;
        w_err   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_abort = 1'b0;
                // A busy serializer is still in its guard phase from the
                // previous packet, so no new frame may start yet.
                if (!bus.fire && w_arb_any) begin
                    w_gnt   = w_arb_gnt;
                    w_idx   = w_arb_idx;
                    w_cnt   = w_len_sel;
                    w_state = ST_ARB;
                end
            end

            ST_ARB: begin
                if (r_cnt == '0) begin
                    // Empty packet: acknowledge without touching the serializer.
                    w_done  = r_gnt;
                    w_gnt   = '0;
                    w_ptr   = w_ptr_next;
                    w_state = ST_IDLE;
                end else begin
                    w_fs    = 1'b1;
                    w_txd   = SYNC_DATA;
                    w_tmo   = '0;
                    w_state = ST_SYNC;
                end
            end

            ST_SYNC: begin
                if (bus.fire) begin
                    w_txd   = w_rdata_sel;
                    w_pop   = r_gnt;
                    w_cnt   = r_cnt - 1'b1;
                    w_slot  = '0;
                    // Dropping fs with the final byte tells the serializer
                    // to enter its guard phase after it.
                    w_fs    = (r_cnt != CNT_ONE);
                    w_state = ST_SEND;
                end else if (r_tmo == TMO_LAST) begin
                    // Serializer never answered; report both err and done
                    // so the requester is released exactly once.
                    w_fs    = 1'b0;
                    w_txd   = '0;
                    w_err   = 1'b1;
                    w_done  = r_gnt;
                    w_abort = 1'b1;
                    w_state = ST_GUARD;
                end else begin
                    w_tmo = r_tmo + 1'b1;
                end
            end

            ST_SEND: begin
                w_slot = r_slot + 3'd1;
                if (slot_end(r_slot)) begin
                    if (r_cnt != '0) begin
                        w_txd = w_rdata_sel;
                        w_pop = r_gnt;
                        w_cnt = r_cnt - 1'b1;
                        w_fs  = (r_cnt != CNT_ONE);
                    end else begin
                        w_fs    = 1'b0;
                        w_txd   = '0;
                        w_state = ST_GUARD;
                    end
                end
            end

            ST_GUARD: begin
                w_txd = '0;
                if (!bus.fire) begin
                    // An aborted packet already signalled done.
                    w_done  = r_abort ? '0 : r_gnt;
                    w_gnt   = '0;
                    w_ptr   = w_ptr_next;
                    w_state = ST_IDLE;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_slot  <= '0;
            r_tmo   <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_abort <= 1'b0;
            r_fs    <= 1'b0;
            r_txd   <= 8'h00;
            r_gnt   <= '0;
            r_pop   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_slot  <= w_slot;
            r_tmo   <= w_tmo;
            r_ptr   <= w_ptr;
            r_idx   <= w_idx;
            r_abort <= w_abort;
            r_fs    <= w_fs;
            r_txd   <= w_txd;
            r_gnt   <= w_gnt;
            r_pop   <= w_pop;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    assign bus.fs   = r_fs;
    assign bus.txd  = r_txd;
    assign bus.gnt  = r_gnt;
    assign bus.pop  = r_pop;
    assign bus.done = r_done;
    assign bus.err  = r_err;

endmodule

// File: tb/tb_usb_tx_sched.sv
// tb_usb_tx_sched: randomized and directed bench for usb_tx_sched with a
// transaction-level reference model (round-robin pick, per-requester byte
// FIFOs, behavioural serializer).
module tb_usb_tx_sched;
    localparam int NREQ   = 2;
    localparam int LEN_W  = 8;
    localparam int TO_CYC = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    usb_tx_sched_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();

    usb_tx_sched #(
        .NREQ   (NREQ),
        .LEN_W  (LEN_W),
        .TO_CYC (TO_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Requester byte FIFOs.
    logic [7:0] mem [NREQ][256];
    int head [NREQ];
    int tail [NREQ];

    // Reference model state.
    int ptr_m = 0;
    bit act = 1'b0;
    int a_idx, a_len, a_pops, last_pop_cyc, rise_cyc;
    bit rose, tmo;
    int pkts_done = 0;
    logic prev_fs = 1'b0;
    logic [NREQ-1:0] prev_gnt = '0;

    // Behavioural serializer.
    int ser_st = 0;
    int ser_cnt = 0;
    int ser_guard = 0;
    bit fire_tied = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic load_pkt(input int i, input int l);
        head[i] = 0;
        tail[i] = 0;
        for (int b = 0; b < l; b++) begin
            mem[i][b] = 8'($urandom_range(0, 255));
            tail[i]++;
        end
        bus.len[i*LEN_W +: LEN_W] = LEN_W'(l);
        bus.rdata[i*8 +: 8] = (l > 0) ? mem[i][0] : 8'h00;
        bus.req[i] = 1'b1;
    endtask

    task automatic set_byte(input int i, input int b, input logic [7:0] v);
        mem[i][b] = v;
        if (b == head[i]) bus.rdata[i*8 +: 8] = v;
    endtask

    // One clock: observe at the falling edge, check against the model,
    // then advance the FIFOs and the serializer.
    task automatic tick();
        int e;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            act = 1'b0; prev_fs = 1'b0; prev_gnt = '0;
            bus.fire = 1'b0; ser_st = 0;
            return;
        end
        if (bus.gnt != '0 && prev_gnt == '0 && !act) begin
            e = rr_pick(bus.req, ptr_m);
            check_val("gnt_pick", bus.gnt, onehot(e));
            act = 1'b1; a_idx = (e < 0) ? 0 : e;
            a_len = int'(bus.len[a_idx*LEN_W +: LEN_W]);
            a_pops = 0; rose = 1'b0; tmo = 1'b0;
        end
        if (bus.fs && !prev_fs) begin
            check_val("fs_rise_txd", bus.txd, 8'h01);
            check_val("fs_rise_fire", bus.fire, 1'b0);
            check_val("fs_rise_len", (act && a_len != 0), 1'b1);
            rose = 1'b1; rise_cyc = cyc;
        end
        if (bus.pop != '0) begin
            check_val("pop_sel", bus.pop, act ? onehot(a_idx) : '0);
            check_val("pop_data", bus.txd, (head[a_idx] < tail[a_idx]) ? mem[a_idx][head[a_idx]] : 9'h100);
            if (a_pops > 0) check_val("pop_gap", cyc - last_pop_cyc, 8);
            a_pops++;
            check_val("pop_fs", bus.fs, (a_pops < a_len));
            last_pop_cyc = cyc;
            if (head[a_idx] < tail[a_idx]) head[a_idx]++;
        end
        if (!bus.fs && prev_fs) begin
            if (bus.err) check_val("fall_tmo_pops", a_pops, 0);
            else         check_val("fall_pops", a_pops, a_len);
        end
        if (bus.err) begin
            check_val("err_cyc", cyc - rise_cyc, TO_CYC);
            check_val("err_mode", fire_tied, 1'b1);
            tmo = 1'b1;
        end
        if (bus.done != '0) begin
            check_val("done_sel", bus.done, act ? onehot(a_idx) : '0);
            check_val("done_fs", bus.fs, 1'b0);
            if (tmo) begin
                check_val("done_tmo_pops", a_pops, 0);
            end else begin
                check_val("done_pops", a_pops, a_len);
                check_val("done_gnt", bus.gnt, '0);
                check_val("done_rose", rose, (a_len != 0));
                check_val("done_txd", bus.txd, 8'h00);
            end
            ptr_m = (a_idx + 1) % NREQ;
            bus.req[a_idx] = 1'b0;
            head[a_idx] = tail[a_idx];
            act = 1'b0;
            pkts_done++;
        end
        for (int i = 0; i < NREQ; i++) begin
            bus.rdata[i*8 +: 8] = (head[i] < tail[i]) ? mem[i][head[i]] : 8'h00;
        end
        case (ser_st)
            0: begin
                bus.fire = 1'b0;
                if (bus.fs && !fire_tied) begin
                    ser_cnt = $urandom_range(0, 5);
                    ser_guard = $urandom_range(1, 4);
                    ser_st = 1;
                end
            end
            1: begin
                if (!bus.fs) ser_st = 0;
                else if (ser_cnt == 0) begin
                    bus.fire = 1'b1; ser_cnt = 0; ser_st = 2;
                end else ser_cnt--;
            end
            default: begin
                if (!bus.fs) begin
                    ser_cnt++;
                    if (ser_cnt >= 8 + ser_guard) begin
                        bus.fire = 1'b0; ser_st = 0;
                    end
                end
            end
        endcase
        prev_fs = bus.fs;
        prev_gnt = bus.gnt;
    endtask

    task automatic run_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (bus.req == '0 && !act && bus.gnt == '0 && !bus.fire) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("idle_reached", ok, 1'b1);
    endtask

    task automatic run_until_done(input int target, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (pkts_done >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("done_reached", ok, 1'b1);
    endtask

    initial begin
        int base;
        bit ok;
        bus.req = '0; bus.len = '0; bus.rdata = '0; bus.fire = 1'b0;
        for (int i = 0; i < NREQ; i++) begin head[i] = 0; tail[i] = 0; end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_fs", bus.fs, 1'b0);
        check_val("rst_txd", bus.txd, 8'h00);
        check_val("rst_gnt", bus.gnt, '0);
        check_val("rst_pop", bus.pop, '0);
        check_val("rst_done", bus.done, '0);
        check_val("rst_err", bus.err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention: both len 1, then requester 0 again behind 1.
        load_pkt(0, 1);
        load_pkt(1, 1);
        run_until_done(1, 300);
        load_pkt(0, 1);
        run_idle(400);

        // Single packet A5,3C,F0 on requester 0.
        load_pkt(0, 3);
        set_byte(0, 0, 8'hA5);
        set_byte(0, 1, 8'h3C);
        set_byte(0, 2, 8'hF0);
        run_idle(400);

        // Zero length on requester 1.
        load_pkt(1, 0);
        run_idle(100);

        // Timeout: serializer never answers.
        fire_tied = 1'b1;
        load_pkt(0, 2);
        run_idle(300);
        fire_tied = 1'b0;

        // Reset during byte 2 of 4 on requester 1 (pointer is 1 here).
        load_pkt(1, 4);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (act && a_pops == 2) begin ok = 1'b1; break; end
        end
        check_val("rst_mid_reached", ok, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check_val("rst_mid_fs", bus.fs, 1'b0);
        check_val("rst_mid_gnt", bus.gnt, '0);
        check_val("rst_mid_txd", bus.txd, 8'h00);
        check_val("rst_mid_pop", bus.pop, '0);
        check_val("rst_mid_done", bus.done, '0);
        check_val("rst_mid_err", bus.err, 1'b0);
        ptr_m = 0; act = 1'b0; bus.req = '0; bus.fire = 1'b0; ser_st = 0;
        for (int i = 0; i < NREQ; i++) head[i] = tail[i];
        @(posedge clk);
        tick();
        rst_n = 1'b1;
        load_pkt(0, 1);
        load_pkt(1, 1);
        run_idle(400);

        // Maximum length.
        load_pkt(0, 255);
        run_idle(2400);

        // Randomized traffic.
        base = pkts_done;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i] && !(act && a_idx == i) && $urandom_range(0, 9) == 0)
                    load_pkt(i, $urandom_range(0, 5));
            end
            if (act && $urandom_range(0, 199) == 0) bus.req[a_idx] = 1'b0;
        end
        run_idle(2000);
        check_val("rand_progress", (pkts_done - base) > 20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
